// File: rtl/decoder_ref_ctrl.sv
// Calibrates the Manchester decoder delay reference from 8 measured line intervals and tracks lock.
// Edges seen 3 osc cycles after the line moves; REF/locked update 1 cycle after the 8th closing edge.
module decoder_ref_ctrl #(
  parameter int MAX_RETRY = 3,
  parameter int BAD_LIMIT = 4
) (
  input  logic       osc,
  input  logic       globalReset,
  input  logic       ManchesterCode,
  input  logic       start,
  output logic [3:0] REF,
  output logic       locked,
  output logic       busy,
  output logic       error
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int BW = $clog2(BAD_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_EDGE, MEASURE, COMPUTE, LOCKED, ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic [5:0]    cnt_q, cnt_d;
  logic [8:0]    sum_q, sum_d;
  logic [4:0]    min_q, min_d, max_q, max_d;
  logic [2:0]    idx_q, idx_d;
  logic [5:0]    avg_q, avg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [BW-1:0] bad_q, bad_d;
  logic [3:0]    ref_q, ref_d;
  logic          locked_q, busy_q, error_q;

  logic       edge_det, cnt_sat, iv_good, in_window, fail, bad_evt;
  logic [5:0] avg_c, spread_lim, lo_b;
  logic [4:0] spread;
  logic [7:0] avg_x3, ref_raw, avg_x5, hi_b;
  logic [3:0] ref_calc;

  assign edge_det   = sync2_q ^ sync3_q;
  assign cnt_sat    = (cnt_q == 6'd63);
  assign iv_good    = (cnt_q >= 6'd2) && (cnt_q <= 6'd31);
  assign avg_c      = sum_q[8:3];
  assign spread     = max_q - min_q;
  assign spread_lim = (avg_c >> 2) + 6'd1;
  assign avg_x3     = {2'b00, avg_c} + {1'b0, avg_c, 1'b0};
  assign ref_raw    = avg_x3 >> 1;
  assign ref_calc   = (ref_raw > 8'd15) ? 4'd15 : ref_raw[3:0];
  assign lo_b       = avg_q >> 1;
  assign avg_x5     = {2'b00, avg_q} + {avg_q, 2'b00};
  assign hi_b       = avg_x5 >> 1;
  assign in_window  = (cnt_q >= lo_b) && ({2'b00, cnt_q} <= hi_b);

  // While locked, a saturated counter restarts so each silent 63-cycle stretch is one bad event.
  always_comb begin
    if (edge_det)                             cnt_d = 6'd1;
    else if (state_q == LOCKED && cnt_sat)    cnt_d = 6'd1;
    else if (cnt_sat)                         cnt_d = 6'd63;
    else                                      cnt_d = cnt_q + 6'd1;
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    idx_d   = idx_q;
    avg_d   = avg_q;
    retry_d = retry_q;
    bad_d   = bad_q;
    ref_d   = ref_q;
    fail    = 1'b0;
    bad_evt = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = WAIT_EDGE;
      WAIT_EDGE: begin
        if (edge_det) begin
          state_d = MEASURE;
          sum_d   = '0;
          min_d   = 5'h1f;
          max_d   = '0;
          idx_d   = '0;
        end
      end
      MEASURE: begin
        if (edge_det) begin
          if (!iv_good) begin
            fail = 1'b1;
          end else begin
            sum_d = sum_q + {3'b000, cnt_q};
            if (cnt_q[4:0] < min_q) min_d = cnt_q[4:0];
            if (cnt_q[4:0] > max_q) max_d = cnt_q[4:0];
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = COMPUTE;
          end
        end else if (cnt_sat) begin
          fail = 1'b1;
        end
      end
      COMPUTE: begin
        avg_d = avg_c;
        if ({1'b0, spread} > spread_lim) begin
          fail = 1'b1;
        end else begin
          ref_d   = ref_calc;
          retry_d = '0;
          bad_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          if (in_window) bad_d = '0;
          else           bad_evt = 1'b1;
        end else if (cnt_sat) begin
          bad_evt = 1'b1;
        end
      end
      ERROR: begin
        if (start) begin
          retry_d = '0;
          state_d = WAIT_EDGE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail) begin
      if (retry_q >= RW'(MAX_RETRY)) begin
        state_d = ERROR;
      end else begin
        retry_d = retry_q + RW'(1);
        state_d = WAIT_EDGE;
      end
    end

    if (bad_evt) begin
      if ((bad_q + BW'(1)) >= BW'(BAD_LIMIT)) begin
        bad_d   = '0;
        retry_d = '0;
        state_d = WAIT_EDGE;
      end else begin
        bad_d = bad_q + BW'(1);
      end
    end
  end

  always_ff @(posedge osc or posedge globalReset) begin
    if (globalReset) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      avg_q    <= '0;
      retry_q  <= '0;
      bad_q    <= '0;
      ref_q    <= 4'b1000;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= ManchesterCode;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      avg_q    <= avg_d;
      retry_q  <= retry_d;
      bad_q    <= bad_d;
      ref_q    <= ref_d;
      locked_q <= (state_d == LOCKED);
      busy_q   <= (state_d == WAIT_EDGE) || (state_d == MEASURE) || (state_d == COMPUTE);
      error_q  <= (state_d == ERROR);
    end
  end

  assign REF    = ref_q;
  assign locked = locked_q;
  assign busy   = busy_q;
  assign error  = error_q;

endmodule

// File: tb/tb_decoder_ref_ctrl.sv
// Directed bench for decoder_ref_ctrl: calibration, lock tracking, retry/error and reset behaviour.
module tb_decoder_ref_ctrl;

  logic       osc = 1'b0;
  logic       globalReset;
  logic       ManchesterCode;
  logic       start;
  logic [3:0] REF;
  logic       locked, busy, error;

  int total = 0;
  int bad   = 0;

  always #5 osc = ~osc;

  decoder_ref_ctrl #(.MAX_RETRY(3), .BAD_LIMIT(4)) dut (
    .osc            (osc),
    .globalReset    (globalReset),
    .ManchesterCode (ManchesterCode),
    .start          (start),
    .REF            (REF),
    .locked         (locked),
    .busy           (busy),
    .error          (error)
  );

  task automatic do_reset();
    #1 globalReset = 1'b1;
    ManchesterCode = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge osc);
    #1 globalReset = 1'b0;
    repeat (2) @(posedge osc);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge osc);
    #1 start = 1'b1;
    @(posedge osc);
    #1 start = 1'b0;
  endtask

  task automatic toggle(input int n, input int count);
    for (int k = 0; k < count; k++) begin
      repeat (n) @(posedge osc);
      #1 ManchesterCode = ~ManchesterCode;
    end
  endtask

  task automatic test_reset();
    globalReset = 1'b1;
    ManchesterCode = 1'b0;
    start = 1'b0;
    #2;
    total++; if (REF !== 4'b1000) begin bad++; $display("FAIL reset_ref: got %h want %h", REF, 4'b1000); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
    @(posedge osc);
    #1 globalReset = 1'b0;
  endtask

  task automatic test_lock10();
    do_reset();
    pulse_start();
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lock10_busy_start: got %b want 1", busy); end
    toggle(10, 9);
    repeat (3) @(posedge osc);
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock10_locked_early: got %b want 0", locked); end
    @(posedge osc);
    #1;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock10_locked: got %b want 1", locked); end
    total++; if (REF !== 4'd15) begin bad++; $display("FAIL lock10_ref: got %0d want 15", REF); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lock10_busy: got %b want 0", busy); end
  endtask

  task automatic test_lock6_track();
    int pat[6];
    pat = '{6, 12, 12, 6, 12, 6};
    do_reset();
    pulse_start();
    toggle(6, 9);
    repeat (4) @(posedge osc);
    #1;
    total++; if (REF !== 4'd9) begin bad++; $display("FAIL lock6_ref: got %0d want 9", REF); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock6_locked: got %b want 1", locked); end
    pulse_start();
    #1;
    total++; if (busy !== 1'b0 || locked !== 1'b1) begin bad++; $display("FAIL lock6_start_ignored: got busy=%b locked=%b want busy=0 locked=1", busy, locked); end
    for (int k = 0; k < 6; k++) toggle(pat[k], 1);
    repeat (4) @(posedge osc);
    #1;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL track_6_12: got %b want 1", locked); end
    toggle(20, 3);
    toggle(6, 1);
    toggle(20, 3);
    repeat (4) @(posedge osc);
    #1;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL track_bad_cleared: got %b want 1", locked); end
    toggle(20, 1);
    repeat (4) @(posedge osc);
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL track_unlock: got %b want 0", locked); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL track_unlock_busy: got %b want 1", busy); end
    total++; if (REF !== 4'd9) begin bad++; $display("FAIL track_unlock_ref: got %0d want 9", REF); end
  endtask

  task automatic test_spread_retry();
    int pat8[8];
    pat8 = '{6, 6, 6, 12, 6, 6, 6, 6};
    do_reset();
    pulse_start();
    for (int k = 0; k < 36; k++) toggle(pat8[k % 8], 1);
    repeat (3) @(posedge osc);
    #1;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL spread_error_early: got %b want 0", error); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL spread_busy: got %b want 1", busy); end
    @(posedge osc);
    #1;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL spread_error: got %b want 1", error); end
    total++; if (locked !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL spread_err_flags: got locked=%b busy=%b want 0 0", locked, busy); end
    pulse_start();
    #1;
    total++; if (error !== 1'b0) begin bad++; $display("FAIL spread_clear_error: got %b want 0", error); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL spread_clear_busy: got %b want 1", busy); end
  endtask

  task automatic test_static_line();
    do_reset();
    pulse_start();
    toggle(6, 9);
    repeat (4) @(posedge osc);
    #1;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL static_lock: got %b want 1", locked); end
    repeat (236) @(posedge osc);
    #1;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL static_still_locked: got %b want 1", locked); end
    repeat (60) @(posedge osc);
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL static_unlock: got %b want 0", locked); end
    total++; if (REF !== 4'd9) begin bad++; $display("FAIL static_ref: got %0d want 9", REF); end
  endtask

  task automatic test_reset_mid_measure();
    toggle(6, 4);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    #2 globalReset = 1'b1;
    #1;
    total++; if (REF !== 4'b1000) begin bad++; $display("FAIL mid_ref: got %h want %h", REF, 4'b1000); end
    total++; if (busy !== 1'b0 || locked !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL mid_flags: got busy=%b locked=%b error=%b want 0 0 0", busy, locked, error); end
    ManchesterCode = 1'b0;
    @(posedge osc);
    #1 globalReset = 1'b0;
    toggle(6, 3);
    repeat (4) @(posedge osc);
    #1;
    total++; if (busy !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL mid_needs_start: got busy=%b locked=%b want 0 0", busy, locked); end
    repeat (10) @(posedge osc);
    pulse_start();
    toggle(8, 9);
    repeat (4) @(posedge osc);
    #1;
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock: got %b want 1", locked); end
    total++; if (REF !== 4'd12) begin bad++; $display("FAIL mid_relock_ref: got %0d want 12", REF); end
  endtask

  task automatic test_fast_line();
    do_reset();
    pulse_start();
    toggle(1, 20);
    repeat (4) @(posedge osc);
    #1;
    total++; if (error !== 1'b1) begin bad++; $display("FAIL fast_error: got %b want 1", error); end
    total++; if (busy !== 1'b0 || locked !== 1'b0) begin bad++; $display("FAIL fast_flags: got busy=%b locked=%b want 0 0", busy, locked); end
    total++; if (REF !== 4'b1000) begin bad++; $display("FAIL fast_ref: got %h want %h", REF, 4'b1000); end
  endtask

  initial begin
    test_reset();
    test_lock10();
    test_lock6_track();
    test_spread_retry();
    test_static_line();
    test_reset_mid_measure();
    test_fast_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_ref_ctrl.md
DECODER_REF_CTRL -- requirements
Module: decoder_ref_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: MAX_RETRY, 3, failed calibration attempts allowed before ERROR; BAD_LIMIT, 4, consecutive bad intervals in LOCKED before unlock.
REQ-002 Port osc, input, 1, sole clock; all state changes on its rising edge.
REQ-003 Port globalReset, input, 1, asynchronous active-high reset.
REQ-004 Port ManchesterCode, input, 1, raw asynchronous line being decoded.
REQ-005 Port start, input, 1, single-cycle pulse that begins calibration.
REQ-006 Port REF, output, 4, delay reference driven to the decoder.
REQ-007 Port locked, output, 1, high while REF is valid and the line is tracked.
REQ-008 Port busy, output, 1, high in WAIT_EDGE, MEASURE and COMPUTE.
REQ-009 Port error, output, 1, sticky calibration failure flag.

Function
REQ-010 ManchesterCode SHALL pass through a 2-flop synchronizer; an edge is a difference between sync stage 2 and a third registered copy, so edge detection lags the line by 3 osc cycles.
REQ-011 A 6-bit interval counter SHALL count osc cycles since the last edge, saturate at 63, and load 1 on the cycle an edge is detected.
REQ-012 An interval is good when its value at the closing edge is 2..31 inclusive; otherwise it is bad.
REQ-013 States SHALL be IDLE, WAIT_EDGE, MEASURE, COMPUTE, LOCKED and ERROR; reset state is IDLE.
REQ-014 IDLE -> WAIT_EDGE on start; start SHALL be ignored in all other states except ERROR.
REQ-015 WAIT_EDGE -> MEASURE on the first edge; sum, min, max and the interval index clear.
REQ-016 MEASURE SHALL capture 8 consecutive intervals: sum (9-bit) accumulates, and min/max (5-bit) track the extremes.
REQ-017 A bad interval or a saturated counter (63) in MEASURE SHALL abort the attempt, increment the retry count and return to WAIT_EDGE.
REQ-018 When the retry count would exceed MAX_RETRY, the FSM SHALL go to ERROR instead of WAIT_EDGE.
REQ-019 After the 8th interval the FSM SHALL enter COMPUTE for exactly one cycle, where avg = sum>>3.
REQ-020 In COMPUTE, if max-min > (avg>>2)+1 the attempt fails under the REQ-017/018 rules.
REQ-021 Otherwise COMPUTE SHALL set REF = min(15, (3*avg)>>1) and go to LOCKED; REF and locked update on the COMPUTE->LOCKED edge, 1 cycle after the 8th edge is detected.
REQ-022 REF SHALL change only on entry to LOCKED and SHALL hold its value in every other state, including after unlock.
REQ-023 In LOCKED each closing interval SHALL be checked: good if (avg>>1) <= interval <= (5*avg)>>1, else bad.
REQ-024 Counter saturation at 63 in LOCKED SHALL count as one bad event, counted once per saturation.
REQ-025 A good interval SHALL clear the bad count; BAD_LIMIT consecutive bad events SHALL deassert locked and go to WAIT_EDGE with the retry count cleared.
REQ-026 ERROR SHALL assert error; start SHALL clear error and the retry count and go to WAIT_EDGE.
REQ-027 The retry count SHALL clear on every entry to LOCKED.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On globalReset, regardless of state, the block SHALL asynchronously set REF=4'b1000, locked=0, busy=0, error=0, state=IDLE, and clear all counters, sum, min, max and the synchronizer.
REQ-030 Deassertion of globalReset mid-MEASURE SHALL leave no partial sum; a new start is required.

Verification
REQ-031 Reset, then start, then a steady toggle every 10 osc cycles -> locked=1 with REF=15 one cycle after the 8th edge; busy=0.
REQ-032 Toggles every 6 cycles -> REF=9; then data pattern with intervals of 6 and 12 -> locked stays 1.
REQ-033 Intervals 6,6,6,12,6,6,6,6 -> spread fails and a retry occurs; after 4 consecutive failures -> error=1; a start pulse then clears error and busy=1.
REQ-034 Locked at avg=6, then line held static for 300 cycles -> locked=0 after 4 saturations, REF still 9.
REQ-035 globalReset asserted mid-MEASURE -> all outputs return to reset values immediately; start with a clean line -> normal lock.
REQ-036 Line toggling every cycle (interval 1) -> every attempt aborts -> error=1 after MAX_RETRY+1 attempts.
